cosim_mailbox_arbiter: RTL and testbench

Shares the single simulator-to-cosim event mailbox between several RTL requesters. Each requester posts one data word. The block picks a winner with round-robin arbitration and latches the word, source index and a sequence number into the mailbox registers. It then holds them until the cosim side (`$apvm` task running on the host) acknowledges, or until a timeout expires. It sits between the testbench value producers and the PLI polling point in the cosim top level.

---
 rtl/cosim_pkg.sv | 15 +
 rtl/cosim_mailbox_arbiter_rr_arbiter.sv | 34 +++
 rtl/cosim_mailbox_arbiter.sv | 138 +++++++++++++
 tb/tb_cosim_mailbox_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_pkg.sv
// Shared types and default sizing for the cosim mailbox arbiter.
// Consumers pull these in with import cosim_pkg::*.
package cosim_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 32;
  localparam int DEF_TMO  = 1024;
  localparam int DEF_SEQW = 8;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/cosim_mailbox_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
// Outputs a one-hot grant and the matching encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SRCW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SRCW-1:0] gnt_idx
);

  logic [SRCW-1:0] cand_idx [NREQ];
  logic            found;

  // cand_idx[k] is the requester examined at priority position k
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand_idx[gi] = SRCW'((32'(rr_ptr) + gi) % NREQ);
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand_idx[k]]) begin
        found   = 1'b1;
        gnt_idx = cand_idx[k];
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/cosim_mailbox_arbiter.sv
// Single-slot simulator-to-cosim mailbox shared by NREQ requesters.
// Captures one event per round-robin grant and holds it until host_ack or timeout.
module cosim_mailbox_arbiter
  import cosim_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int TMO  = DEF_TMO,
  parameter int SEQW = DEF_SEQW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          grant,
  output logic                     mbox_valid,
  output logic [DW-1:0]            mbox_data,
  output logic [$clog2(NREQ)-1:0]  mbox_src,
  output logic [SEQW-1:0]          mbox_seq,
  input  logic                     host_ack,
  output logic                     tmo_pulse,
  output logic                     tmo_err
);

  localparam int              SRCW      = $clog2(NREQ);
  localparam int              TW        = $clog2(TMO);
  localparam logic [TW-1:0]   WAIT_LAST = TW'(TMO - 1);
  localparam logic [SRCW-1:0] SRC_LAST  = SRCW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [SEQW-1:0] seq_cnt_q, seq_cnt_d;
  logic [SRCW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            mbox_valid_q, mbox_valid_d;
  logic [DW-1:0]   mbox_data_q, mbox_data_d;
  logic [SRCW-1:0] mbox_src_q, mbox_src_d;
  logic [SEQW-1:0] mbox_seq_q, mbox_seq_d;
  logic            tmo_pulse_q, tmo_pulse_d;
  logic            tmo_err_q, tmo_err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [SRCW-1:0] arb_idx;
  logic [DW-1:0]   req_words [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign req_words[gi] = req_data[gi*DW +: DW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    seq_cnt_d    = seq_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    wait_cnt_d   = wait_cnt_q;
    grant_d      = '0;
    mbox_valid_d = mbox_valid_q;
    mbox_data_d  = mbox_data_q;
    mbox_src_d   = mbox_src_q;
    mbox_seq_d   = mbox_seq_q;
    tmo_pulse_d  = 1'b0;
    tmo_err_d    = tmo_err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d      = arb_gnt;
          mbox_data_d  = req_words[arb_idx];
          mbox_src_d   = arb_idx;
          mbox_seq_d   = seq_cnt_q;
          seq_cnt_d    = seq_cnt_q + SEQW'(1);
          mbox_valid_d = 1'b1;
          wait_cnt_d   = '0;
          state_d      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        // An ack landing on the final wait cycle takes precedence over the timeout
        if (host_ack || (wait_cnt_q == WAIT_LAST)) begin
          mbox_valid_d = 1'b0;
          rr_ptr_d     = (mbox_src_q == SRC_LAST) ? '0 : mbox_src_q + SRCW'(1);
          state_d      = IDLE;
          if (!host_ack) begin
            tmo_pulse_d = 1'b1;
            tmo_err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      seq_cnt_q    <= '0;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      grant_q      <= '0;
      mbox_valid_q <= 1'b0;
      mbox_data_q  <= '0;
      mbox_src_q   <= '0;
      mbox_seq_q   <= '0;
      tmo_pulse_q  <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_cnt_q    <= seq_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      grant_q      <= grant_d;
      mbox_valid_q <= mbox_valid_d;
      mbox_data_q  <= mbox_data_d;
      mbox_src_q   <= mbox_src_d;
      mbox_seq_q   <= mbox_seq_d;
      tmo_pulse_q  <= tmo_pulse_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign grant      = grant_q;
  assign mbox_valid = mbox_valid_q;
  assign mbox_data  = mbox_data_q;
  assign mbox_src   = mbox_src_q;
  assign mbox_seq   = mbox_seq_q;
  assign tmo_pulse  = tmo_pulse_q;
  assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_cosim_mailbox_arbiter.sv
// Directed bench for cosim_mailbox_arbiter: reset, capture, round-robin order,
// fairness, timeout, ack/timeout collision and asynchronous reset mid-event.
module tb_cosim_mailbox_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int SEQW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      grant;
  logic                 mbox_valid;
  logic [DW-1:0]        mbox_data;
  logic [1:0]           mbox_src;
  logic [SEQW-1:0]      mbox_seq;
  logic                 host_ack;
  logic                 tmo_pulse;
  logic                 tmo_err;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] words [NREQ];

  always #5 clk = ~clk;

  cosim_mailbox_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .TMO  (TMO),
    .SEQW (SEQW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .mbox_valid (mbox_valid),
    .mbox_data  (mbox_data),
    .mbox_src   (mbox_src),
    .mbox_seq   (mbox_seq),
    .host_ack   (host_ack),
    .tmo_pulse  (tmo_pulse),
    .tmo_err    (tmo_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant != '0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    host_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic ack_event();
    step();
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    host_ack = 1'b0;
    step();
    step();
    checks++;
    if ({grant, mbox_valid, mbox_data, mbox_src, mbox_seq, tmo_pulse, tmo_err} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got grant=%b valid=%b data=%h src=%0d seq=%0d tp=%b te=%b required all zero",
               grant, mbox_valid, mbox_data, mbox_src, mbox_seq, tmo_pulse, tmo_err);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({grant, mbox_valid, tmo_pulse, tmo_err} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got grant=%b valid=%b tp=%b te=%b required all zero",
               grant, mbox_valid, tmo_pulse, tmo_err);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit seen;
    req = 4'b0001;
    wait_grant(seen);
    req = '0;
    checks++;
    if (!seen) begin errors++; $display("FAIL single_grant_wait: got no grant required grant within 8 cycles"); end
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b required 0001", grant); end
    checks++;
    if (mbox_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", mbox_valid); end
    checks++;
    if (mbox_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h required deadbeef", mbox_data); end
    checks++;
    if (mbox_src !== 2'd0) begin errors++; $display("FAIL single_src: got %0d required 0", mbox_src); end
    checks++;
    if (mbox_seq !== 8'd0) begin errors++; $display("FAIL single_seq: got %0d required 0", mbox_seq); end
    step();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_pulse: got %b required 0000", grant); end
    repeat (3) step();
    checks++;
    if (mbox_valid !== 1'b1) begin errors++; $display("FAIL single_valid_hold: got %b required 1", mbox_valid); end
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
    checks++;
    if (mbox_valid !== 1'b0) begin errors++; $display("FAIL single_ack_valid: got %b required 0", mbox_valid); end
    checks++;
    if (mbox_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_keep: got %h required deadbeef", mbox_data); end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    bit seen;
    int exp_src;
    logic [NREQ-1:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_src = i % NREQ;
      exp_gnt = 4'b0001 << exp_src;
      wait_grant(seen);
      if (i == 4) req = '0;
      checks++;
      if (!seen) begin errors++; $display("FAIL rr_wait[%0d]: got no grant required grant within 8 cycles", i); end
      checks++;
      if (grant !== exp_gnt) begin errors++; $display("FAIL rr_grant[%0d]: got %b required %b", i, grant, exp_gnt); end
      checks++;
      if (mbox_seq !== SEQW'(i)) begin errors++; $display("FAIL rr_seq[%0d]: got %0d required %0d", i, mbox_seq, i); end
      checks++;
      if (mbox_data !== words[exp_src]) begin errors++; $display("FAIL rr_data[%0d]: got %h required %h", i, mbox_data, words[exp_src]); end
      ack_event();
      checks++;
      if (mbox_valid !== 1'b0) begin errors++; $display("FAIL rr_ack[%0d]: got valid=%b required 0", i, mbox_valid); end
      $display("rr event %0d: grant=%b src=%0d seq=%0d", i, exp_gnt, exp_src, i);
    end
  endtask

  task automatic test_fairness();
    bit seen;
    do_reset();
    req = 4'b0010;
    wait_grant(seen);
    req = '0;
    checks++;
    if (mbox_src !== 2'd1) begin errors++; $display("FAIL fair_setup_src: got %0d required 1", mbox_src); end
    ack_event();
    req = 4'b1001;
    wait_grant(seen);
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL fair_first: got %b required 1000", grant); end
    ack_event();
    wait_grant(seen);
    req = '0;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL fair_second: got %b required 0001", grant); end
    ack_event();
    $display("test_fairness done");
  endtask

  task automatic test_timeout();
    bit seen;
    bit fell;
    int cnt;
    do_reset();
    req = 4'b0100;
    wait_grant(seen);
    req = '0;
    checks++;
    if ({mbox_src, mbox_seq} !== {2'd2, 8'd0}) begin
      errors++;
      $display("FAIL tmo_capture: got src=%0d seq=%0d required src=2 seq=0", mbox_src, mbox_seq);
    end
    cnt = 1;
    fell = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mbox_valid) cnt++;
      else begin
        fell = 1'b1;
        break;
      end
    end
    checks++;
    if (!fell) begin errors++; $display("FAIL tmo_fall: got valid stuck high required fall within 40 cycles"); end
    checks++;
    if (cnt != TMO) begin errors++; $display("FAIL tmo_width: got %0d cycles required %0d", cnt, TMO); end
    checks++;
    if (tmo_pulse !== 1'b1) begin errors++; $display("FAIL tmo_pulse_hi: got %b required 1", tmo_pulse); end
    checks++;
    if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b required 1", tmo_err); end
    step();
    checks++;
    if (tmo_pulse !== 1'b0) begin errors++; $display("FAIL tmo_pulse_lo: got %b required 0", tmo_pulse); end
    checks++;
    if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b required 1", tmo_err); end
    req = 4'b0001;
    wait_grant(seen);
    req = '0;
    checks++;
    if (mbox_seq !== 8'd1) begin errors++; $display("FAIL tmo_next_seq: got %0d required 1", mbox_seq); end
    checks++;
    if (mbox_src !== 2'd0) begin errors++; $display("FAIL tmo_next_src: got %0d required 0", mbox_src); end
    ack_event();
    checks++;
    if ({mbox_valid, tmo_pulse, tmo_err} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_after_ack: got valid=%b tp=%b te=%b required 0 0 1", mbox_valid, tmo_pulse, tmo_err);
    end
    $display("test_timeout done");
  endtask

  task automatic test_ack_on_timeout();
    bit seen;
    do_reset();
    req = 4'b0001;
    wait_grant(seen);
    req = '0;
    repeat (TMO - 1) step();
    checks++;
    if (mbox_valid !== 1'b1) begin errors++; $display("FAIL race_valid_before: got %b required 1", mbox_valid); end
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
    checks++;
    if ({mbox_valid, tmo_pulse, tmo_err} !== 3'b000) begin
      errors++;
      $display("FAIL race_exit: got valid=%b tp=%b te=%b required 0 0 0", mbox_valid, tmo_pulse, tmo_err);
    end
    step();
    checks++;
    if ({tmo_pulse, tmo_err} !== 2'b00) begin
      errors++;
      $display("FAIL race_after: got tp=%b te=%b required 0 0", tmo_pulse, tmo_err);
    end
    $display("test_ack_on_timeout done");
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    req = 4'b0100;
    wait_grant(seen);
    req = '0;
    ack_event();
    req = 4'b1000;
    wait_grant(seen);
    req = '0;
    checks++;
    if ({mbox_src, mbox_seq} !== {2'd3, 8'd1}) begin
      errors++;
      $display("FAIL mid_setup: got src=%0d seq=%0d required src=3 seq=1", mbox_src, mbox_seq);
    end
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({grant, mbox_valid, mbox_data, mbox_src, mbox_seq, tmo_pulse} !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: got valid=%b data=%h src=%0d seq=%0d tp=%b required all zero",
               mbox_valid, mbox_data, mbox_src, mbox_seq, tmo_pulse);
    end
    #1;
    rst = 1'b0;
    req = 4'b1111;
    wait_grant(seen);
    req = '0;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL mid_next_grant: got %b required 0001", grant); end
    checks++;
    if ({mbox_src, mbox_seq} !== {2'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_next_event: got src=%0d seq=%0d required src=0 seq=0", mbox_src, mbox_seq);
    end
    ack_event();
    checks++;
    if ({mbox_valid, tmo_pulse, tmo_err} !== 3'b000) begin
      errors++;
      $display("FAIL mid_final: got valid=%b tp=%b te=%b required 0 0 0", mbox_valid, tmo_pulse, tmo_err);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    words[0] = 32'hDEADBEEF;
    words[1] = 32'hCAFE0001;
    words[2] = 32'hCAFE0002;
    words[3] = 32'hCAFE0003;
    req_data = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hDEADBEEF};
    rst = 1'b1;
    req = '0;
    host_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
